// File: rtl/vector_lsu.sv
// vector_lsu: vector load/store initiator for the 512x32 data memory.
// One op in flight; load data returns on a valid/ready channel.
module vector_lsu #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 512,
  parameter int LANES  = 16,
  parameter int VREG_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VREG_W-1:0] req_vreg,
  input  logic [DATA_W-1:0] req_wr_data,
  output logic              mem_wr_enable,
  output logic              mem_rd_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [VREG_W-1:0] rsp_vreg,
  output logic [DATA_W-1:0] rsp_data,
  output logic              store_done,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
);

  localparam int LANE_W = DATA_W / LANES;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } state_t;

  state_t state, state_n;

  logic              is_store, is_store_n;
  logic [VREG_W-1:0] vreg, vreg_n;

  logic              req_ready_n;
  logic              wr_en_n;
  logic              rd_en_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              rsp_valid_n;
  logic [VREG_W-1:0] rsp_vreg_n;
  logic [DATA_W-1:0] rsp_data_n;
  logic              done_n;
  logic [CNT_W-1:0]  lcnt_n;
  logic [CNT_W-1:0]  scnt_n;

  logic [DATA_W-1:0] wr_lanes;

  // Lane k of the request goes to lane k of the write bus;
  // the memory applies the (base + k) mod 512 placement.
  always_comb begin
    wr_lanes = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_lanes[k*LANE_W +: LANE_W] = req_wr_data[k*LANE_W +: LANE_W];
    end
  end

  // Next state and next registered outputs; strobes and
  // store_done default low so they last exactly one cycle.
  always_comb begin
    state_n     = state;
    is_store_n  = is_store;
    vreg_n      = vreg;
    req_ready_n = req_ready;
    wr_en_n     = 1'b0;
    rd_en_n     = 1'b0;
    addr_n      = mem_addr;
    wdata_n     = mem_wr_data;
    rsp_valid_n = rsp_valid;
    rsp_vreg_n  = rsp_vreg;
    rsp_data_n  = rsp_data;
    done_n      = 1'b0;
    lcnt_n      = load_count;
    scnt_n      = store_count;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_n     = ISSUE;
          is_store_n  = req_is_store;
          vreg_n      = req_vreg;
          req_ready_n = 1'b0;
          addr_n      = req_addr;
          wdata_n     = wr_lanes;
          wr_en_n     = req_is_store;
          rd_en_n     = !req_is_store;
        end
      end
      ISSUE: begin
        if (is_store) begin
          state_n     = IDLE;
          req_ready_n = 1'b1;
          done_n      = 1'b1;
          scnt_n      = store_count + CNT_W'(1);
        end else begin
          state_n = CAPT;
        end
      end
      CAPT: begin
        state_n     = RESP;
        rsp_data_n  = mem_rd_data;
        rsp_vreg_n  = vreg;
        rsp_valid_n = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
          lcnt_n      = load_count + CNT_W'(1);
        end
      end
      default: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      is_store      <= 1'b0;
      vreg          <= '0;
      req_ready     <= 1'b1;
      mem_wr_enable <= 1'b0;
      mem_rd_enable <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      rsp_valid     <= 1'b0;
      rsp_vreg      <= '0;
      rsp_data      <= '0;
      store_done    <= 1'b0;
      load_count    <= '0;
      store_count   <= '0;
    end else begin
      state         <= state_n;
      is_store      <= is_store_n;
      vreg          <= vreg_n;
      req_ready     <= req_ready_n;
      mem_wr_enable <= wr_en_n;
      mem_rd_enable <= rd_en_n;
      mem_addr      <= addr_n;
      mem_wr_data   <= wdata_n;
      rsp_valid     <= rsp_valid_n;
      rsp_vreg      <= rsp_vreg_n;
      rsp_data      <= rsp_data_n;
      store_done    <= done_n;
      load_count    <= lcnt_n;
      store_count   <= scnt_n;
    end
  end

  // Read and write strobes come from one state and never overlap.
  always @(posedge clock) begin
    if (!rst) begin
      assert (!(mem_wr_enable && mem_rd_enable));
    end
  end

endmodule
